// File: rtl/reg_access_ctrl_if.sv
// Request/response channel between a requester and reg_access_ctrl.
interface reg_access_ctrl_if #(
    parameter int ADSize = 5,
    parameter int DASize = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADSize-1:0] req_rs1;
    logic [ADSize-1:0] req_rs2;
    logic [ADSize-1:0] req_rd;
    logic [DASize-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DASize-1:0] rsp_data1;
    logic [DASize-1:0] rsp_data2;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_rd, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data1, rsp_data2
    );
endinterface

// File: rtl/reg_access_ctrl.sv
// Initiator-side sequencer for the 32x32 register file: read-pair, write and
// clear commands in, registered register-file pins and read responses out.
//
// state | meaning
// IDLE  | ready for a request, all strobes low
// WR    | single write strobe cycle
// RD    | single read strobe cycle with both addresses driven
// CAP   | wait for OUT_1/OUT_2, captured at the end of this cycle
// RESP  | response presented until consumed
// CLR   | one zero-write per cycle sweeping 0..REGSize-1
module reg_access_ctrl #(
    parameter int ADSize  = 5,
    parameter int REGSize = 32,
    parameter int DASize  = 32
) (
    input  logic              clk,
    input  logic              rst,
    reg_access_ctrl_if.slave  bus,
    output logic              busy,
    output logic              enable,
    output logic              Write,
    output logic              Read,
    output logic [ADSize-1:0] Read_ADDR_1,
    output logic [ADSize-1:0] Read_ADDR_2,
    output logic [ADSize-1:0] Write_ADDR,
    output logic [DASize-1:0] DIN,
    input  logic [DASize-1:0] OUT_1,
    input  logic [DASize-1:0] OUT_2
);

    localparam int CntW = (REGSize > 1) ? $clog2(REGSize) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REGSize - 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_RESP,
        S_CLR
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DASize-1:0] data1_q, data1_d;
    logic [DASize-1:0] data2_q, data2_d;
    logic              busy_q, busy_d;
    logic              enable_q, enable_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [ADSize-1:0] raddr1_q, raddr1_d;
    logic [ADSize-1:0] raddr2_q, raddr2_d;
    logic [ADSize-1:0] waddr_q, waddr_d;
    logic [DASize-1:0] din_q, din_d;
    logic              accept;

    assign accept = bus.req_valid && req_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        raddr1_d    = raddr1_q;
        raddr2_d    = raddr2_q;
        waddr_d     = waddr_q;
        din_d       = din_q;

        unique case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    unique case (bus.req_op)
                        OP_WRITE: begin
                            state_d = S_WR;
                            write_d = 1'b1;
                            waddr_d = bus.req_rd;
                            din_d   = bus.req_wdata;
                        end
                        OP_READ: begin
                            state_d  = S_RD;
                            read_d   = 1'b1;
                            raddr1_d = bus.req_rs1;
                            raddr2_d = bus.req_rs2;
                        end
                        OP_CLEAR: begin
                            state_d = S_CLR;
                            cnt_d   = '0;
                            write_d = 1'b1;
                            waddr_d = '0;
                            din_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d = S_RESP;
                data1_d = OUT_1;
                data2_d = OUT_2;
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            S_CLR: begin
                // cnt_q is the address being written in the current cycle
                if (cnt_q == CntLast) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    write_d = 1'b1;
                    waddr_d = ADSize'(cnt_d);
                    din_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        enable_d = write_d | read_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            busy_q      <= 1'b0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            waddr_q     <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            busy_q      <= busy_d;
            enable_q    <= enable_d;
            write_q     <= write_d;
            read_q      <= read_d;
            raddr1_q    <= raddr1_d;
            raddr2_q    <= raddr2_d;
            waddr_q     <= waddr_d;
            din_q       <= din_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data1 = data1_q;
    assign bus.rsp_data2 = data2_q;
    assign busy          = busy_q;
    assign enable        = enable_q;
    assign Write         = write_q;
    assign Read          = read_q;
    assign Read_ADDR_1   = raddr1_q;
    assign Read_ADDR_2   = raddr2_q;
    assign Write_ADDR    = waddr_q;
    assign DIN           = din_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file and a
// response scoreboard fed from a shadow copy of the register contents.
module tb_reg_access_ctrl;
    localparam int ADSize  = 5;
    localparam int REGSize = 32;
    localparam int DASize  = 32;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef struct packed {
        logic [DASize-1:0] d1;
        logic [DASize-1:0] d2;
    } rsp_t;

    logic              clk;
    logic              rst;
    logic              busy, enable, Write, Read;
    logic [ADSize-1:0] Read_ADDR_1, Read_ADDR_2, Write_ADDR;
    logic [DASize-1:0] DIN, OUT_1, OUT_2;

    logic [DASize-1:0] regfile [REGSize];
    logic [DASize-1:0] shadow  [REGSize];
    logic [DASize-1:0] saved   [REGSize];
    rsp_t              exp_q [$];
    int                n_assert = 0;
    int                n_fail   = 0;

    reg_access_ctrl_if #(.ADSize(ADSize), .DASize(DASize)) bus ();

    reg_access_ctrl #(.ADSize(ADSize), .REGSize(REGSize), .DASize(DASize)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .enable      (enable),
        .Write       (Write),
        .Read        (Read),
        .Read_ADDR_1 (Read_ADDR_1),
        .Read_ADDR_2 (Read_ADDR_2),
        .Write_ADDR  (Write_ADDR),
        .DIN         (DIN),
        .OUT_1       (OUT_1),
        .OUT_2       (OUT_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reg_32x32: no reset, read data registered one edge after Read
    always @(posedge clk) begin
        if (enable && Write) regfile[Write_ADDR] <= DIN;
        if (enable && Read) begin
            OUT_1 <= regfile[Read_ADDR_1];
            OUT_2 <= regfile[Read_ADDR_2];
        end
    end

    task automatic check(input string tag, input logic [DASize-1:0] obs,
                         input logic [DASize-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        rsp_t e;
        if (rst && bus.rsp_valid && bus.rsp_ready) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL rsp_unexpected: observed response 0x%0h/0x%0h expected none",
                       bus.rsp_data1, bus.rsp_data2);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_data1", bus.rsp_data1, e.d1);
                check("rsp_data2", bus.rsp_data2, e.d2);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [ADSize-1:0] rs1,
                         input logic [ADSize-1:0] rs2, input logic [ADSize-1:0] rd,
                         input logic [DASize-1:0] wd);
        int budget;
        bus.req_op    = op;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_rd    = rd;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        budget = 0;
        while (!bus.req_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("req_ready_wait", DASize'(bus.req_ready), DASize'(1));
        if (bus.req_ready) begin
            @(posedge clk); #1;
            if (op == OP_READ) exp_q.push_back('{d1: shadow[rs1], d2: shadow[rs2]});
            else if (op == OP_WRITE) shadow[rd] = wd;
            else if (op == OP_CLEAR) for (int i = 0; i < REGSize; i++) shadow[i] = '0;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("rsp_drained", DASize'(exp_q.size()), '0);
    endtask

    initial begin
        int budget;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_NOP;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        OUT_1         = '0;
        OUT_2         = '0;
        for (int i = 0; i < REGSize; i++) begin
            regfile[i] = '0;
            shadow[i]  = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", DASize'({busy, enable, Write, Read, bus.req_ready, bus.rsp_valid}), '0);
        check("rst_addr", DASize'({Read_ADDR_1, Read_ADDR_2, Write_ADDR}), '0);
        check("rst_din", DIN, '0);
        check("rst_rsp", bus.rsp_data1 | bus.rsp_data2, '0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", DASize'({bus.req_ready, busy}), DASize'(2'b10));

        for (int i = 0; i < 4; i++) begin
            issue(OP_WRITE, '0, '0, ADSize'(i), DASize'(i + 1));
            check("wr_strobe", DASize'({enable, Write, Read, bus.req_ready, busy}), DASize'(5'b11001));
            check("wr_addr", DASize'(Write_ADDR), DASize'(i));
            check("wr_din", DIN, DASize'(i + 1));
            @(posedge clk); #1;
            check("wr_done", DASize'({enable, Write, Read, bus.req_ready, busy}), DASize'(5'b00010));
            check("wr_peek", regfile[i], DASize'(i + 1));
        end

        issue(OP_READ, 5'd1, 5'd3, '0, '0);
        check("rd_strobe", DASize'({enable, Write, Read}), DASize'(3'b101));
        check("rd_addr", DASize'({Read_ADDR_1, Read_ADDR_2}), DASize'({5'd1, 5'd3}));
        check("rd_lat_n1", DASize'(bus.rsp_valid), '0);
        @(posedge clk); #1;
        check("rd_lat_n1_strobe", DASize'({enable, Read, bus.rsp_valid}), '0);
        @(posedge clk); #1;
        check("rd_lat_n2", DASize'(bus.rsp_valid), '0);
        @(posedge clk); #1;
        check("rd_lat_n3", DASize'({bus.rsp_valid, bus.req_ready}), DASize'(2'b10));
        @(posedge clk); #1;
        check("rd_lat_n4", DASize'({bus.rsp_valid, bus.req_ready}), DASize'(2'b01));
        check("rd_queue", DASize'(exp_q.size()), '0);

        bus.rsp_ready = 1'b0;
        issue(OP_READ, 5'd0, 5'd2, '0, '0);
        budget = 0;
        while (!bus.rsp_valid && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check("stall_valid", DASize'(bus.rsp_valid), DASize'(1));
        for (int i = 0; i < 5; i++) begin
            check("stall_ctrl", DASize'({bus.rsp_valid, bus.req_ready, busy}), DASize'(3'b101));
            check("stall_d1", bus.rsp_data1, DASize'(1));
            check("stall_d2", bus.rsp_data2, DASize'(3));
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", DASize'({bus.rsp_valid, bus.req_ready}), DASize'(2'b01));

        issue(OP_WRITE, '0, '0, 5'd2, 32'hF);
        issue(OP_READ, 5'd2, 5'd2, '0, '0);
        wait_rsp();
        @(posedge clk); #1;
        check("hold_after_hs", bus.rsp_data1, 32'hF);
        check("hold_valid_low", DASize'(bus.rsp_valid), '0);

        issue(OP_NOP, '0, '0, '0, '0);
        check("nop_accept", DASize'({bus.req_ready, busy, enable}), '0);
        @(posedge clk); #1;
        check("nop_back", DASize'({bus.req_ready, bus.rsp_valid}), DASize'(2'b10));

        issue(OP_CLEAR, '0, '0, '0, '0);
        for (int i = 0; i < REGSize; i++) begin
            check("clr_ctrl", DASize'({busy, enable, Write, Read, bus.req_ready}), DASize'(5'b11100));
            check("clr_addr", DASize'(Write_ADDR), DASize'(i));
            check("clr_din", DIN, '0);
            @(posedge clk); #1;
        end
        check("clr_end", DASize'({busy, enable, Write, bus.req_ready}), DASize'(4'b0001));
        issue(OP_READ, 5'd1, 5'd3, '0, '0);
        wait_rsp();

        issue(OP_WRITE, '0, '0, 5'd9,  32'h99);
        issue(OP_WRITE, '0, '0, 5'd10, 32'hAA);
        issue(OP_WRITE, '0, '0, 5'd11, 32'h1111);
        issue(OP_WRITE, '0, '0, 5'd12, 32'h2222);
        @(posedge clk); #1;
        for (int i = 0; i < REGSize; i++) saved[i] = shadow[i];
        issue(OP_CLEAR, '0, '0, '0, '0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("midclr_addr", DASize'({Write, Write_ADDR}), DASize'({1'b1, 5'd10}));
        #2 rst = 1'b0;
        #1;
        check("midclr_async", DASize'({busy, enable, Write, bus.req_ready, bus.rsp_valid}), '0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < REGSize; i++) shadow[i] = (i < 10) ? '0 : saved[i];
        @(posedge clk); #1;
        check("midclr_peek10", regfile[10], 32'hAA);
        check("midclr_ready", DASize'({bus.req_ready, busy}), DASize'(2'b10));
        issue(OP_READ, 5'd11, 5'd12, '0, '0);
        wait_rsp();
        issue(OP_READ, 5'd10, 5'd9, '0, '0);
        wait_rsp();

        check("final_queue", DASize'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
Initiator-side controller for the 32x32 register file (reg_32x32). It accepts read-pair, write and clear commands over a valid/ready request channel. It sequences the register file's enable/Write/Read/address/DIN pins and captures OUT_1/OUT_2. Read results are returned over a valid/ready response channel. It sits between datapath/test logic and the register file, so the register file is never driven directly.

Parameters:
ADSize, 5, register address width
REGSize, 32, number of registers; clear sweeps 0..REGSize-1
DASize, 32, data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid && req_ready at rising edge
req_op  input  2  00 READ, 01 WRITE, 10 CLEAR, 11 NOP
req_rs1  input  ADSize  READ address 1
req_rs2  input  ADSize  READ address 2
req_rd  input  ADSize  WRITE address
req_wdata  input  DASize  WRITE data
rsp_valid  output  1  read response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_data1  output  DASize  data from req_rs1
rsp_data2  output  DASize  data from req_rs2
busy  output  1  high in any state other than IDLE
enable  output  1  to register file; equals Read | Write
Write  output  1  register file write strobe
Read  output  1  register file read strobe
Read_ADDR_1  output  ADSize  register file read address 1
Read_ADDR_2  output  ADSize  register file read address 2
Write_ADDR  output  ADSize  register file write address
DIN  output  DASize  register file write data
OUT_1  input  DASize  register file read data 1; valid the cycle after Read is sampled
OUT_2  input  DASize  register file read data 2; same timing as OUT_1

Behaviour:
- All outputs are registered.
- rst low, asynchronous: state goes to IDLE, clear counter to 0, and every output to 0, except req_ready, which goes to 1 once rst is released. Any operation in progress is abandoned; no response is produced for it.
- FSM states: IDLE, WR, RD, CAP, RESP, CLR.
- IDLE: req_ready=1, and all register-file strobes are 0. On accept, req_ready drops to 0 and the state moves as follows:
  - WRITE goes to WR.
  - READ goes to RD.
  - CLEAR goes to CLR with the counter at 0.
  - NOP stays in IDLE and produces no response.
- WR: for exactly one cycle, enable=1, Write=1, Write_ADDR=req_rd and DIN=req_wdata (latched at accept). Then IDLE. Write throughput is 1 per 2 cycles.
- RD: for one cycle, enable=1, Read=1, Read_ADDR_1=rs1 and Read_ADDR_2=rs2 (latched). Then CAP.
- CAP: strobes are 0. OUT_1/OUT_2 are sampled at the end of this cycle into rsp_data1/rsp_data2. Then RESP.
- RESP: rsp_valid=1. rsp_data1/rsp_data2 are held stable until the handshake. On rsp_valid && rsp_ready, rsp_valid goes to 0 and the state goes to IDLE.
- Read latency: accept at edge N; rsp_valid is high from edge N+3. If rsp_ready is held high, req_ready returns at N+4.
- CLR: each cycle drives enable=1, Write=1, Write_ADDR=cnt, DIN=0, then cnt increments. After the cnt=REGSize-1 cycle the state goes to IDLE. Total is exactly REGSize cycles; there is no wrap beyond REGSize-1.
- Read and Write are never high in the same cycle.
- Addresses and DIN keep their last values while the strobes are 0.
- Requests arriving while busy are not accepted, because req_ready=0. The requester holds its request.
- No forwarding is needed: a write completes before the next request is accepted. A READ issued immediately after a WRITE to the same address returns the new data.
- rsp_data1/rsp_data2 keep their last captured values after the handshake.

Test Plan:
- Reset: hold rst=0 for 2 cycles → all outputs 0, busy=0. After release, req_ready=1.
- Write sequence: WRITE regs 0..3 with data 1,2,3,4 → each produces one cycle of Write=1 with the matching Write_ADDR/DIN, and req_ready low for 1 cycle per write. Bench peeks Regfile[0..3] = 1,2,3,4.
- Reads:
  - READ rs1=1, rs2=3 → rsp_valid 3 cycles after accept, with rsp_data1=2 and rsp_data2=4.
  - Hold rsp_ready=0 for 5 cycles → data and rsp_valid stay stable, and req_ready stays 0.
  - Back-to-back WRITE rd=2 data=0xF, then READ rs1=2, rs2=2 → both data outputs return 0xF.
- CLEAR: after the writes, issue CLEAR → 32 consecutive cycles of Write=1 with Write_ADDR 0..31 and DIN=0, and busy=1 for those 32 cycles. A following READ rs1=1, rs2=3 returns 0 and 0.
- Reset mid-op: assert rst during the CLEAR sweep at cnt=10 → strobes drop immediately (asynchronously), with no further writes. After release, a READ rs1=11, rs2=12 returns the pre-clear values.
